intdiv_seq: RTL and testbench

- Parametrised sequential radix-2 integer divider, successor to the combinational final-adjust logic of the divider datapath.
- Issues one signed-digit (SD2) quotient digit per cycle by non-restoring iteration and converts quotient digits on the fly.
- Applies the final remainder/quotient sign adjustment in a dedicated cycle.
- Adds per-operation signed/unsigned mode, divide-by-zero and overflow handling, and a start/done handshake.

---
 rtl/intdiv_pkg.sv | 26 ++
 rtl/intdiv_otf.sv | 67 ++++++
 rtl/intdiv_seq.sv | 210 +++++++++++++++++++++
 tb/tb_intdiv_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/intdiv_pkg.sv
// rtl/intdiv_pkg.sv - shared encodings and state type for the sequential divider
//
// Purpose: signed-digit (SD2) quotient digit codes, sign-bit meanings and the
// divider control state enum, shared by intdiv_seq and intdiv_otf.
// Ports: none (package).
package intdiv_pkg;

  // SD2 quotient digit encodings; both 01 and 10 mean +1.
  localparam logic [1:0] NEG1   = 2'b11;
  localparam logic [1:0] ZERO   = 2'b00;
  localparam logic [1:0] POS1_1 = 2'b01;
  localparam logic [1:0] POS1_2 = 2'b10;

  // Meaning of a two's-complement sign bit.
  localparam logic NEGATIVE = 1'b1;
  localparam logic POSITIVE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ITER,
    ADJ,
    DONE
  } state_e;

endpackage

// File: rtl/intdiv_otf.sv
// rtl/intdiv_otf.sv - on-the-fly SD2 quotient converter
//
// Purpose: accumulates SD2 quotient digits MSB-first into a conventional
// binary quotient without carry propagation, keeping Q and QM = Q-1.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart conversion (Q = 0, QM = -1)
//   en        - consume one digit this cycle
//   digit     - SD2 digit (NEG1, ZERO, POS1_1, POS1_2)
//   q_val     - registered Q
//   qm_val    - registered QM = Q - 1
module intdiv_otf
  import intdiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_val,
  output logic [W-1:0] qm_val
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] accm_q, accm_d;

  always_comb begin
    acc_d  = acc_q;
    accm_d = accm_q;
    if (clr) begin
      acc_d  = '0;
      accm_d = '1;
    end else if (en) begin
      case (digit)
        ZERO: begin
          acc_d  = {acc_q[W-2:0], 1'b0};
          accm_d = {accm_q[W-2:0], 1'b1};
        end
        NEG1: begin
          acc_d  = {accm_q[W-2:0], 1'b1};
          accm_d = {accm_q[W-2:0], 1'b0};
        end
        default: begin
          // POS1_1 and POS1_2
          acc_d  = {acc_q[W-2:0], 1'b1};
          accm_d = {acc_q[W-2:0], 1'b0};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      accm_q <= '1;
    end else begin
      acc_q  <= acc_d;
      accm_q <= accm_d;
    end
  end

  assign q_val  = acc_q;
  assign qm_val = accm_q;

endmodule

// File: rtl/intdiv_seq.sv
// rtl/intdiv_seq.sv - sequential radix-2 non-restoring integer divider
//
// Purpose: truncating signed/unsigned division, one SD2 quotient digit per
// cycle, with a dedicated sign fix-up cycle and divide-by-zero/overflow
// short cuts.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - request, sampled when not busy (IDLE or DONE)
//   signed_op    - 1: two's-complement operands, 0: unsigned
//   y, x         - dividend, divisor
//   busy         - high in CHECK, ITER, ADJ
//   done         - one-cycle pulse; q, r, div_by_zero valid from here
//   q, r         - quotient, remainder (held until overwritten)
//   div_by_zero  - set with done when x == 0
module intdiv_seq
  import intdiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] y,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_q, rem_d;      // partial remainder, W+1 bits
  logic [W-1:0]  dvd_q, dvd_d;      // dividend bits still to shift in
  logic [W:0]    x_q, x_d;          // extended divisor
  logic          ysign_q, ysign_d;
  logic          sgn_q, sgn_d;
  logic [W-1:0]  qres_q, qres_d;
  logic [W-1:0]  rres_q, rres_d;
  logic          dbz_q, dbz_d;

  logic          otf_clr, otf_en;
  logic [1:0]    digit;
  logic [W-1:0]  otf_q, otf_qm;

  logic          rem_sgn_eq_x;
  logic [W:0]    rem_sh, rem_nx;
  logic          x_zero, ovf;
  logic          in_ysign, in_xsign;

  logic          fix_a, hit_pos, hit_neg, q_up, q_dn;
  logic [W:0]    rem_a, neg_x;
  logic [W-1:0]  adj_q, adj_r;

  intdiv_otf #(.W(W)) u_otf (
    .clk    (clk),
    .rst    (rst),
    .clr    (otf_clr),
    .en     (otf_en),
    .digit  (digit),
    .q_val  (otf_q),
    .qm_val (otf_qm)
  );

  // Non-restoring step. The true value 2*rem+bit -/+ x always lands back in
  // the W+1 bit range, so modulo-2^(W+1) arithmetic gives it exactly.
  always_comb begin
    rem_sgn_eq_x = (rem_q[W] == x_q[W]);
    rem_sh       = {rem_q[W-1:0], dvd_q[W-1]};
    rem_nx       = rem_sgn_eq_x ? (rem_sh - x_q) : (rem_sh + x_q);
    digit        = rem_sgn_eq_x ? POS1_1 : NEG1;
  end

  // Final fix-up. Step (a) and step (b) never both fire: when (a) fires
  // |rem| <= |x| and the correction lands strictly inside (-|x|, |x|).
  always_comb begin
    neg_x = -x_q;
    fix_a = (rem_q != '0) && (rem_q[W] != ysign_q);
    rem_a = rem_q;
    if (fix_a) begin
      rem_a = rem_sgn_eq_x ? (rem_q - x_q) : (rem_q + x_q);
    end
    hit_pos = (rem_a == x_q);
    hit_neg = (rem_a == neg_x);
    q_up    = (fix_a && rem_sgn_eq_x) || hit_pos;
    q_dn    = (fix_a && !rem_sgn_eq_x) || hit_neg;
    adj_r   = (hit_pos || hit_neg) ? '0 : rem_a[W-1:0];
    // q-1 comes for free from QM; only q+1 needs an incrementer.
    if (q_up) begin
      adj_q = otf_q + W'(1);
    end else if (q_dn) begin
      adj_q = otf_qm;
    end else begin
      adj_q = otf_q;
    end
  end

  always_comb begin
    in_ysign = signed_op ? y[W-1] : POSITIVE;
    in_xsign = signed_op ? x[W-1] : POSITIVE;
    x_zero   = (x_q == '0);
    ovf      = sgn_q && (dvd_q == {1'b1, {(W-1){1'b0}}}) && (x_q[W-1:0] == '1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    x_d     = x_q;
    ysign_d = ysign_q;
    sgn_d   = sgn_q;
    qres_d  = qres_q;
    rres_d  = rres_q;
    dbz_d   = dbz_q;
    otf_clr = 1'b0;
    otf_en  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CHECK;
          rem_d   = {(W+1){in_ysign}};
          dvd_d   = y;
          x_d     = {in_xsign, x};
          ysign_d = in_ysign;
          sgn_d   = signed_op;
          dbz_d   = 1'b0;
          otf_clr = 1'b1;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (x_zero) begin
          state_d = DONE;
          dbz_d   = 1'b1;
          qres_d  = '1;
          rres_d  = dvd_q;
        end else if (ovf) begin
          state_d = DONE;
          qres_d  = dvd_q;
          rres_d  = '0;
        end else begin
          // The first digit is issued here so the W digits plus the
          // fix-up cycle fit in W+1 busy cycles.
          state_d = ITER;
          rem_d   = rem_nx;
          dvd_d   = {dvd_q[W-2:0], 1'b0};
          otf_en  = 1'b1;
          cnt_d   = CW'(W - 1);
        end
      end
      ITER: begin
        rem_d  = rem_nx;
        dvd_d  = {dvd_q[W-2:0], 1'b0};
        otf_en = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ADJ;
        end
      end
      ADJ: begin
        state_d = DONE;
        qres_d  = adj_q;
        rres_d  = adj_r;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      x_q     <= '0;
      ysign_q <= 1'b0;
      sgn_q   <= 1'b0;
      qres_q  <= '0;
      rres_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      x_q     <= x_d;
      ysign_q <= ysign_d;
      sgn_q   <= sgn_d;
      qres_q  <= qres_d;
      rres_q  <= rres_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CHECK) || (state_q == ITER) || (state_q == ADJ);
  assign done        = (state_q == DONE);
  assign q           = qres_q;
  assign r           = rres_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// tb/tb_intdiv_seq.sv - directed self-checking bench for intdiv_seq
module tb_intdiv_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] y;
  logic [W-1:0] x;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  intdiv_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .y           (y),
    .x           (x),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request; caller is at a negedge (cycle 0 of the operation).
  task automatic launch(input logic sgn, input logic [W-1:0] yv, input logic [W-1:0] xv);
    start     = 1'b1;
    signed_op = sgn;
    y         = yv;
    x         = xv;
  endtask

  // Follows the operation cycle by cycle; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edbz, input int elat, input bit poke);
    int busy_cnt = 0;
    bit seen     = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check_val({tag, " dbz_cleared"}, div_by_zero, 0);
      end
      if (done) begin
        seen = 1'b1;
        check_val({tag, " latency"}, k, elat);
        check_val({tag, " busy_cycles"}, busy_cnt, elat - 1);
        check_val({tag, " busy_at_done"}, busy, 0);
        check_val({tag, " q"}, q, eq);
        check_val({tag, " r"}, r, er);
        check_val({tag, " dbz"}, div_by_zero, edbz);
      end else if (busy) begin
        busy_cnt++;
      end
      if (poke && k == 5) begin
        start     = 1'b1;
        signed_op = 1'b0;
        y         = 16'h0001;
        x         = 16'h0001;
      end
      if (poke && k == 6) start = 1'b0;
    end
    check_val({tag, " done_seen"}, seen, 1);
  endtask

  task automatic run_vec(input string tag, input logic sgn, input logic [W-1:0] yv,
                         input logic [W-1:0] xv, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edbz, input int elat);
    launch(sgn, yv, xv);
    wait_done(tag, eq, er, edbz, elat, 1'b0);
    @(negedge clk);
    check_val({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    int done_cnt;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    y         = '0;
    x         = '0;
    repeat (2) @(negedge clk);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset q", q, 0);
    check_val("reset r", r, 0);
    check_val("reset dbz", div_by_zero, 0);
    rst = 1'b0;

    //      tag          sgn   y          x          q          r          dbz lat
    run_vec("s7/2",      1'b1, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 18);
    run_vec("s-7/2",     1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18);
    run_vec("s7/-2",     1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18);
    run_vec("s-7/-2",    1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 18);
    run_vec("s-6/3",     1'b1, 16'hFFFA, 16'h0003, 16'hFFFE, 16'h0000, 1'b0, 18);
    run_vec("s6/-3",     1'b1, 16'h0006, 16'hFFFD, 16'hFFFE, 16'h0000, 1'b0, 18);
    run_vec("s-6/-3",    1'b1, 16'hFFFA, 16'hFFFD, 16'h0002, 16'h0000, 1'b0, 18);
    run_vec("u5/0",      1'b0, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 2);
    run_vec("s_ovf",     1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 2);
    run_vec("u8000/ffff",1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18);
    run_vec("uffff/10",  1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 18);
    run_vec("sffff/10",  1'b1, 16'hFFFF, 16'h0010, 16'h0000, 16'hFFFF, 1'b0, 18);
    run_vec("uffff/ffff",1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 18);
    run_vec("u0/7",      1'b0, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 1'b0, 18);
    run_vec("s8000/1",   1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18);
    run_vec("s8000/2",   1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 18);

    // start while busy is ignored
    launch(1'b1, 16'h0007, 16'h0002);
    wait_done("busy_start", 16'h0003, 16'h0001, 1'b0, 18, 1'b1);
    @(negedge clk);
    check_val("busy_start done_one_cycle", done, 0);

    // back-to-back: new start accepted in the DONE cycle
    launch(1'b0, 16'd100, 16'd7);
    wait_done("chain_a", 16'd14, 16'd2, 1'b0, 18, 1'b0);
    launch(1'b1, 16'hFFF9, 16'h0002);
    wait_done("chain_b", 16'hFFFD, 16'hFFFF, 1'b0, 18, 1'b0);
    @(negedge clk);

    // reset in the middle of an operation
    launch(1'b0, 16'hFFFF, 16'h0010);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 6) rst = 1'b1;
    end
    @(negedge clk);
    check_val("midrst busy", busy, 0);
    check_val("midrst done", done, 0);
    check_val("midrst q", q, 0);
    check_val("midrst r", r, 0);
    check_val("midrst dbz", div_by_zero, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("midrst no_done", done_cnt, 0);

    run_vec("post_rst u9/3", 1'b0, 16'h0009, 16'h0003, 16'h0003, 16'h0000, 1'b0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
